edac_err_logger: RTL and testbench
==================================

// Module: edac_err_logger
// PURPOSE
//  Read-side consumer of the EDAC ECC/scrubber flags. It counts correctable,
//  uncorrectable and scrub-writeback events, and logs each failing RAM address
//  into a small FIFO. It captures the first uncorrectable address and raises a
//  level interrupt. Sits between the EDAC flag outputs (correctable, error,
//  scrub_corr, ram_rA_lat) and the TTC CPU register interface, on rClk.
// PARAMETERS
//  RAM_LOGDEPTH  8   width of logged RAM address (matches EDAC RAM_LOGDEPTH)
//  CNT_WIDTH     16  width of each saturating event counter
//  LOG_LOGDEPTH  3   log FIFO depth = 2**LOG_LOGDEPTH entries
//  CORR_THRESH   16  corr_cnt value at/above which irq fires; 0 disables
// PORTS
//  rClk            in   1               single clock (EDAC read clock)
//  rst             in   1               synchronous, active-high reset
//  correctable     in   1               EDAC: corrected single-bit error this cycle
//  error           in   1               EDAC: uncorrectable error this cycle
//  scrub_corr      in   1               EDAC: scrubber write-back this cycle
//  err_addr        in   RAM_LOGDEPTH    failing address (EDAC ram_rA_lat), aligned to flags
//  clr_cnt         in   1               pulse: clear counters, sticky flags, capture reg
//  log_pop         in   1               consume head of log FIFO
//  log_valid       out  1               log FIFO non-empty
//  log_type        out  1               head entry type: 0=correctable, 1=uncorrectable
//  log_addr        out  RAM_LOGDEPTH    head entry address
//  log_ovf         out  1               sticky: entry dropped because FIFO full
//  corr_cnt        out  CNT_WIDTH       correctable event count
//  unc_cnt         out  CNT_WIDTH       uncorrectable event count
//  scrub_cnt       out  CNT_WIDTH       scrub write-back count
//  first_unc_vld   out  1               sticky: first_unc_addr holds a capture
//  first_unc_addr  out  RAM_LOGDEPTH    address of first uncorrectable since clear
//  irq             out  1               level interrupt
// BEHAVIOUR
//  - Reset: all outputs, counters, FIFO pointers and sticky flags are 0. irq=0.
//  - Event classification per cycle: error=1 -> UNC (even if correctable=1);
//    correctable=1 & error=0 -> CORR. scrub_corr is counted independently.
//  - Counters: +1 per qualifying cycle. They saturate at all-ones with no wrap.
//    The new value is visible on the outputs one cycle after the flag.
//  - clr_cnt: clears the counters, log_ovf, first_unc_vld and first_unc_addr.
//    If an event arrives in the same cycle, the clear applies first, then the
//    event: the counter becomes 1 and capture/overflow follow the same order.
//    The log FIFO contents are not affected by clr_cnt.
//  - Capture: on an UNC with first_unc_vld=0, latch err_addr and set
//    first_unc_vld. Later UNCs do not overwrite the capture.
//  - Log FIFO: a CORR or UNC pushes {type, err_addr}. Head is first-word-fall-
//    through on log_type/log_addr while log_valid=1.
//    * pop while empty: ignored.
//    * push while full and no pop: entry dropped, log_ovf set.
//    * push and pop in the same cycle while full: both happen, nothing
//      dropped, and the occupancy stays full.
//    * push into empty: log_valid rises the next cycle.
//    * pointers wrap modulo 2**LOG_LOGDEPTH; occupancy is an extra-bit counter.
//  - irq (registered) = (unc_cnt!=0) | log_ovf |
//    (CORR_THRESH!=0 & corr_cnt>=CORR_THRESH).
//    It is asserted the cycle after the causing counter/flag updates, and
//    deasserts the cycle after clr_cnt if no new event arrives.
//  - rst mid-operation: returns to the reset state the next edge; in-flight
//    flags from that cycle are discarded.
// STRUCTURE
//  - Shared include edac_log_defs.v: LOG_TYPE_CORR=1'b0, LOG_TYPE_UNC=1'b1,
//    entry width macro (RAM_LOGDEPTH+1).
//  - Sub-module edac_log_fifo: sync FWFT FIFO, params WIDTH/LOGDEPTH, ports
//    rClk, rst, push, din, pop, dout, valid, full. Overflow and sticky logic
//    stay in the top.
//  - Counters are a generate-replicated saturating incrementer with sync clear.
// TESTING
//  1 reset -> all outputs 0; 3 cycles correctable=1, addr 0x10..0x12 ->
//    corr_cnt=3, 3 CORR log entries in order, irq=0 (CORR_THRESH=16).
//  2 error=1 at addr 0x2A, later error=1 at 0x33 -> unc_cnt=2,
//    first_unc_addr=0x2A, first_unc_vld=1, irq=1 the cycle after the first.
//  3 10 CORR events with no pop (depth 8) -> 8 entries kept (first 8 addrs),
//    log_ovf=1, irq=1; then a full-FIFO push+pop same cycle -> no drop,
//    occupancy remains 8.
//  4 corr_cnt preloaded to 0xFFFF via 65535 events (or CNT_WIDTH=4: 20
//    events) -> counter holds all-ones, no wrap.
//  5 clr_cnt coincident with error=1 at 0x05 -> unc_cnt=1,
//    first_unc_addr=0x05, log_ovf=0; clr_cnt alone -> irq drops the next cycle.
//  6 correctable=1 and error=1 same cycle -> unc_cnt+1 only, log_type=1;
//    scrub_corr pulses x4 -> scrub_cnt=4, no log entries.

Source files
------------

// File: rtl/edac_err_logger_pkg.sv
// Shared definitions for the EDAC error logger: log entry type codes,
// counter indices and entry-width helper.
package edac_err_logger_pkg;

  localparam logic LOG_TYPE_CORR = 1'b0;
  localparam logic LOG_TYPE_UNC  = 1'b1;

  typedef enum int {
    CNT_CORR  = 0,
    CNT_UNC   = 1,
    CNT_SCRUB = 2
  } cnt_idx_e;

  localparam int NUM_CNT = 3;

  // A log entry is {type, address}.
  function automatic int entry_w(input int ram_logdepth);
    return ram_logdepth + 1;
  endfunction

endpackage

// File: rtl/edac_err_logger_fifo.sv
// Synchronous first-word-fall-through FIFO for the error log; a push while
// full is accepted only when a pop frees a slot in the same cycle.
module edac_log_fifo #(
  parameter int WIDTH    = 9,
  parameter int LOGDEPTH = 3
) (
  input  logic             rClk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int DEPTH = 2 ** LOGDEPTH;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr;
  logic [LOGDEPTH-1:0] rd_ptr;
  logic [LOGDEPTH:0]   count;
  logic                do_push;
  logic                do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (LOGDEPTH+1)'(DEPTH));
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge rClk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge rClk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/edac_err_logger.sv
// EDAC flag consumer: saturating event counters, failing-address log FIFO,
// first-uncorrectable capture and a registered level interrupt.
module edac_err_logger
  import edac_err_logger_pkg::*;
#(
  parameter int RAM_LOGDEPTH = 8,
  parameter int CNT_WIDTH    = 16,
  parameter int LOG_LOGDEPTH = 3,
  parameter int CORR_THRESH  = 16
) (
  input  logic                    rClk,
  input  logic                    rst,
  input  logic                    correctable,
  input  logic                    error,
  input  logic                    scrub_corr,
  input  logic [RAM_LOGDEPTH-1:0] err_addr,
  input  logic                    clr_cnt,
  input  logic                    log_pop,
  output logic                    log_valid,
  output logic                    log_type,
  output logic [RAM_LOGDEPTH-1:0] log_addr,
  output logic                    log_ovf,
  output logic [CNT_WIDTH-1:0]    corr_cnt,
  output logic [CNT_WIDTH-1:0]    unc_cnt,
  output logic [CNT_WIDTH-1:0]    scrub_cnt,
  output logic                    first_unc_vld,
  output logic [RAM_LOGDEPTH-1:0] first_unc_addr,
  output logic                    irq
);

  localparam int ENT_W = entry_w(RAM_LOGDEPTH);
  localparam int EXT_W = CNT_WIDTH + 32;

  logic               is_unc;
  logic               is_corr;
  logic [NUM_CNT-1:0] inc;
  logic               push;
  logic [ENT_W-1:0]   fifo_din;
  logic [ENT_W-1:0]   fifo_dout;
  logic               fifo_valid;
  logic               fifo_full;
  logic               drop;
  logic               vld_base;
  logic               thr_hit;

  // Uncorrectable wins when both flags are raised together.
  assign is_unc  = error;
  assign is_corr = correctable & ~error;

  assign inc[CNT_CORR]  = is_corr;
  assign inc[CNT_UNC]   = is_unc;
  assign inc[CNT_SCRUB] = scrub_corr;

  // Clear and increment in the same cycle leaves the counter at 1.
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] q;
    always_ff @(posedge rClk) begin
      if (rst)
        q <= '0;
      else if (clr_cnt)
        q <= CNT_WIDTH'(inc[i]);
      else if (inc[i] && (q != '1))
        q <= q + 1'b1;
    end
  end

  assign corr_cnt  = g_cnt[CNT_CORR].q;
  assign unc_cnt   = g_cnt[CNT_UNC].q;
  assign scrub_cnt = g_cnt[CNT_SCRUB].q;

  assign push     = is_unc | is_corr;
  assign fifo_din = {(is_unc ? LOG_TYPE_UNC : LOG_TYPE_CORR), err_addr};

  edac_log_fifo #(
    .WIDTH    (ENT_W),
    .LOGDEPTH (LOG_LOGDEPTH)
  ) u_fifo (
    .rClk  (rClk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (log_pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign log_valid             = fifo_valid;
  assign {log_type, log_addr}  = fifo_valid ? fifo_dout : '0;

  // A full FIFO only drops when no pop frees a slot this cycle.
  assign drop = push & fifo_full & ~log_pop;

  always_ff @(posedge rClk) begin
    if (rst)
      log_ovf <= 1'b0;
    else
      log_ovf <= (log_ovf & ~clr_cnt) | drop;
  end

  assign vld_base = first_unc_vld & ~clr_cnt;

  always_ff @(posedge rClk) begin
    if (rst) begin
      first_unc_vld  <= 1'b0;
      first_unc_addr <= '0;
    end else if (is_unc && !vld_base) begin
      first_unc_vld  <= 1'b1;
      first_unc_addr <= err_addr;
    end else if (clr_cnt) begin
      first_unc_vld  <= 1'b0;
      first_unc_addr <= '0;
    end
  end

  if (CORR_THRESH != 0) begin : g_thr
    assign thr_hit = EXT_W'(corr_cnt) >= EXT_W'($unsigned(CORR_THRESH));
  end else begin : g_nothr
    assign thr_hit = 1'b0;
  end

  // Interrupt follows the registered state one cycle later; a clear drops it at once.
  always_ff @(posedge rClk) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= ~clr_cnt & ((unc_cnt != '0) | log_ovf | thr_hit);
  end

endmodule

// File: tb/tb_edac_err_logger.sv
// Directed bench for edac_err_logger with a queue-based reference model checked every cycle.
module tb_edac_err_logger;

  localparam int AW    = 8;
  localparam int CW    = 5;
  localparam int CMAX  = 31;
  localparam int THR   = 16;
  localparam int DEPTH = 8;

  logic          rClk = 1'b0;
  logic          rst;
  logic          correctable;
  logic          error;
  logic          scrub_corr;
  logic [AW-1:0] err_addr;
  logic          clr_cnt;
  logic          log_pop;
  logic          log_valid;
  logic          log_type;
  logic [AW-1:0] log_addr;
  logic          log_ovf;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] unc_cnt;
  logic [CW-1:0] scrub_cnt;
  logic          first_unc_vld;
  logic [AW-1:0] first_unc_addr;
  logic          irq;

  edac_err_logger #(
    .RAM_LOGDEPTH (AW),
    .CNT_WIDTH    (CW),
    .LOG_LOGDEPTH (3),
    .CORR_THRESH  (THR)
  ) dut (
    .rClk           (rClk),
    .rst            (rst),
    .correctable    (correctable),
    .error          (error),
    .scrub_corr     (scrub_corr),
    .err_addr       (err_addr),
    .clr_cnt        (clr_cnt),
    .log_pop        (log_pop),
    .log_valid      (log_valid),
    .log_type       (log_type),
    .log_addr       (log_addr),
    .log_ovf        (log_ovf),
    .corr_cnt       (corr_cnt),
    .unc_cnt        (unc_cnt),
    .scrub_cnt      (scrub_cnt),
    .first_unc_vld  (first_unc_vld),
    .first_unc_addr (first_unc_addr),
    .irq            (irq)
  );

  always #5 rClk = ~rClk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_corr, m_unc, m_scrub;
  bit          m_ovf, m_fv, m_irq;
  logic [AW-1:0] m_fa;
  logic [AW:0] m_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_update(input bit c, input bit e, input bit s, input logic [AW-1:0] a,
                              input bit clr, input bit pop, input bit r);
    bit unc, corr, push, popd, irq_n;
    if (r) begin
      m_corr = 0; m_unc = 0; m_scrub = 0;
      m_ovf = 0; m_fv = 0; m_fa = '0; m_irq = 0;
      m_q.delete();
      return;
    end
    irq_n = !clr && (m_unc != 0 || m_ovf || m_corr >= THR);
    if (clr) begin
      m_corr = 0; m_unc = 0; m_scrub = 0;
      m_ovf = 0; m_fv = 0; m_fa = '0;
    end
    unc  = e;
    corr = c && !e;
    if (corr) m_corr  = sat_inc(m_corr);
    if (unc)  m_unc   = sat_inc(m_unc);
    if (s)    m_scrub = sat_inc(m_scrub);
    if (unc && !m_fv) begin
      m_fv = 1;
      m_fa = a;
    end
    push = unc || corr;
    popd = pop && (m_q.size() > 0);
    if (popd) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() >= DEPTH) m_ovf = 1;
      else m_q.push_back({unc, a});
    end
    m_irq = irq_n;
  endtask

  task automatic compare_all();
    logic [AW:0] head;
    head = (m_q.size() > 0) ? m_q[0] : '0;
    check("log_valid", 32'(log_valid), 32'(m_q.size() > 0));
    check("log_type", 32'(log_type), 32'(head[AW]));
    check("log_addr", 32'(log_addr), 32'(head[AW-1:0]));
    check("log_ovf", 32'(log_ovf), 32'(m_ovf));
    check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
    check("unc_cnt", 32'(unc_cnt), 32'(m_unc));
    check("scrub_cnt", 32'(scrub_cnt), 32'(m_scrub));
    check("first_unc_vld", 32'(first_unc_vld), 32'(m_fv));
    check("first_unc_addr", 32'(first_unc_addr), 32'(m_fa));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic step(input bit c, input bit e, input bit s, input logic [AW-1:0] a,
                      input bit clr, input bit pop, input bit r);
    correctable = c; error = e; scrub_corr = s; err_addr = a;
    clr_cnt = clr; log_pop = pop; rst = r;
    @(posedge rClk);
    model_update(c, e, s, a, clr, pop, r);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic drain(output int n, output logic [AW-1:0] first, output logic [AW-1:0] last);
    n = 0; first = '0; last = '0;
    for (int i = 0; i < 20 && log_valid; i++) begin
      if (n == 0) first = log_addr;
      last = log_addr;
      n++;
      step(0, 0, 0, 8'h00, 0, 1, 0);
    end
  endtask

  int            n;
  logic [AW-1:0] fa, la;

  initial begin
    step(0, 0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 0, 8'h00, 0, 0, 1);
    check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_log_valid", 32'(log_valid), 32'd0);

    // 1: three correctables logged in order
    for (int i = 0; i < 3; i++) step(1, 0, 0, AW'(8'h10 + i), 0, 0, 0);
    idle();
    check("t1_corr_cnt", 32'(corr_cnt), 32'd3);
    check("t1_irq", 32'(irq), 32'd0);
    check("t1_head0", 32'({log_type, log_addr}), 32'h010);
    step(0, 0, 0, 8'h00, 0, 1, 0);
    check("t1_head1", 32'({log_type, log_addr}), 32'h011);
    step(0, 0, 0, 8'h00, 0, 1, 0);
    check("t1_head2", 32'({log_type, log_addr}), 32'h012);
    step(0, 0, 0, 8'h00, 0, 1, 0);
    check("t1_empty", 32'(log_valid), 32'd0);

    // 2: first-uncorrectable capture
    step(0, 1, 0, 8'h2A, 0, 0, 0);
    check("t2_irq_lag", 32'(irq), 32'd0);
    idle();
    check("t2_irq", 32'(irq), 32'd1);
    step(0, 1, 0, 8'h33, 0, 0, 0);
    idle();
    check("t2_unc_cnt", 32'(unc_cnt), 32'd2);
    check("t2_first_addr", 32'(first_unc_addr), 32'h2A);
    check("t2_first_vld", 32'(first_unc_vld), 32'd1);
    drain(n, fa, la);
    check("t2_drain_n", 32'(n), 32'd2);
    step(0, 0, 0, 8'h00, 1, 0, 0);
    idle();

    // 3: overflow, then full push+pop
    for (int i = 0; i < 10; i++) step(1, 0, 0, AW'(8'h40 + i), 0, 0, 0);
    idle();
    check("t3_ovf", 32'(log_ovf), 32'd1);
    check("t3_irq", 32'(irq), 32'd1);
    step(1, 0, 0, 8'h50, 0, 1, 0);
    drain(n, fa, la);
    check("t3_occupancy", 32'(n), 32'd8);
    check("t3_first", 32'(fa), 32'h41);
    check("t3_last", 32'(la), 32'h50);

    // 4: saturation with a continuously drained log
    step(0, 0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, AW'(i), 0, 1, 0);
    idle();
    check("t4_corr_sat", 32'(corr_cnt), 32'd31);
    check("t4_irq_thr", 32'(irq), 32'd1);
    check("t4_ovf", 32'(log_ovf), 32'd0);
    drain(n, fa, la);

    // 5: clear coincident with an uncorrectable
    step(0, 1, 0, 8'h05, 1, 0, 0);
    check("t5_unc_cnt", 32'(unc_cnt), 32'd1);
    check("t5_first_addr", 32'(first_unc_addr), 32'h05);
    check("t5_ovf", 32'(log_ovf), 32'd0);
    check("t5_corr_cnt", 32'(corr_cnt), 32'd0);
    idle();
    check("t5_irq_on", 32'(irq), 32'd1);
    step(0, 0, 0, 8'h00, 1, 0, 0);
    check("t5_irq_off", 32'(irq), 32'd0);
    idle();
    drain(n, fa, la);

    // 6: both flags together, then scrubs
    step(1, 1, 0, 8'h77, 0, 0, 0);
    check("t6_unc_cnt", 32'(unc_cnt), 32'd1);
    check("t6_corr_cnt", 32'(corr_cnt), 32'd0);
    check("t6_log_type", 32'(log_type), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 0, 0, 0);
    check("t6_scrub_cnt", 32'(scrub_cnt), 32'd4);
    drain(n, fa, la);
    check("t6_one_entry", 32'(n), 32'd1);

    // 7: reset mid-operation discards the in-flight event
    step(1, 0, 1, 8'h99, 0, 0, 0);
    step(1, 1, 1, 8'h99, 0, 0, 1);
    check("t7_unc_cnt", 32'(unc_cnt), 32'd0);
    check("t7_log_valid", 32'(log_valid), 32'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
